operand_latch: RTL and testbench

Parametrised multi-channel operand latch between the register file and the ALU. It generalises the single 16-bit, p3-loaded operand register to `NCH` channels of `WIDTH` bits each. Per channel it adds an immediate select, same-cycle writeback bypass, late writeback snooping while a value is held, a valid flag, stall, flush and consume. It sits in the p3 (operand fetch) phase and feeds the ALU operand inputs.

---
 rtl/proc_pkg.sv | 14 +
 rtl/operand_latch_if.sv | 40 ++++
 rtl/operand_channel.sv | 111 +++++++++++
 rtl/operand_latch.sv | 51 +++++
 tb/tb_operand_latch.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared processor constants for the operand-fetch stage.
//   DEF_WIDTH : default operand width in bits
//   DEF_NCH   : default number of operand channels
//   DEF_AW    : default register address width
//   WORD_ZERO : reset value for an operand word
package proc_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_NCH   = 2;
  localparam int unsigned DEF_AW    = 3;

  localparam logic [DEF_WIDTH-1:0] WORD_ZERO = '0;

endpackage

// File: rtl/operand_latch_if.sv
// Bus between the register file / writeback path and the operand latch.
//   master : drives p3/stall/flush/consume, register reads, immediate and
//            writeback; receives data_to_ALU, valid, fwd_hit
//   slave  : the operand latch itself
interface operand_latch_if
  import proc_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NCH   = DEF_NCH,
  parameter int unsigned AW    = DEF_AW
);

  logic                 p3;
  logic                 stall;
  logic                 flush;
  logic                 consume;
  logic [NCH*AW-1:0]    rs_addr;
  logic [NCH*WIDTH-1:0] rf_data;
  logic [NCH-1:0]       imm_sel;
  logic [WIDTH-1:0]     imm;
  logic                 wb_en;
  logic [AW-1:0]        wb_addr;
  logic [WIDTH-1:0]     wb_data;
  logic [NCH*WIDTH-1:0] data_to_ALU;
  logic [NCH-1:0]       valid;
  logic [NCH-1:0]       fwd_hit;

  modport master (
    output p3, stall, flush, consume, rs_addr, rf_data, imm_sel, imm,
           wb_en, wb_addr, wb_data,
    input  data_to_ALU, valid, fwd_hit
  );

  modport slave (
    input  p3, stall, flush, consume, rs_addr, rf_data, imm_sel, imm,
           wb_en, wb_addr, wb_data,
    output data_to_ALU, valid, fwd_hit
  );

endinterface

// File: rtl/operand_channel.sv
// One operand channel: holds data/tag/is_reg/valid/fwd_hit, loads on capture
// (immediate, register read or same-cycle writeback bypass) and snoops later
// writebacks to the held register while the operand is still valid.
//   clock, reset        : clock, async active-high reset
//   p3, stall, flush    : capture request, capture block, invalidate
//   consume             : ALU took the operand, clears valid
//   rs_addr, rf_data    : this channel's source index and register read data
//   imm_sel, imm        : select the shared immediate instead of a register
//   wb_en/addr/data     : writeback port, used for bypass and snoop
//   data, valid, fwd_hit: registered channel outputs
module operand_channel
  import proc_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             p3,
  input  logic             stall,
  input  logic             flush,
  input  logic             consume,
  input  logic [AW-1:0]    rs_addr,
  input  logic [WIDTH-1:0] rf_data,
  input  logic             imm_sel,
  input  logic [WIDTH-1:0] imm,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             fwd_hit
);

  localparam logic [WIDTH-1:0] DATA_RST = WIDTH'(WORD_ZERO);

  logic [AW-1:0]    tag;
  logic             is_reg;

  logic [WIDTH-1:0] data_n;
  logic [AW-1:0]    tag_n;
  logic             is_reg_n;
  logic             valid_n;
  logic             fwd_hit_n;

  logic capture;
  logic bypass;
  logic snoop;

  assign capture = p3 & ~stall & ~flush;
  // Register 0 is an ordinary index here; matching is on the raw address.
  assign bypass  = wb_en & (wb_addr == rs_addr);
  assign snoop   = valid & is_reg & wb_en & (wb_addr == tag);

  always_comb begin
    data_n    = data;
    tag_n     = tag;
    is_reg_n  = is_reg;
    valid_n   = valid;
    fwd_hit_n = fwd_hit;

    if (flush) begin
      valid_n  = 1'b0;
      is_reg_n = 1'b0;
    end else if (capture) begin
      valid_n = 1'b1;
      if (imm_sel) begin
        data_n    = imm;
        is_reg_n  = 1'b0;
        fwd_hit_n = 1'b0;
      end else begin
        tag_n    = rs_addr;
        is_reg_n = 1'b1;
        if (bypass) begin
          data_n    = wb_data;
          fwd_hit_n = 1'b1;
        end else begin
          data_n    = rf_data;
          fwd_hit_n = 1'b0;
        end
      end
    end else begin
      // Snoop and consume are independent: a snooped value still lands
      // even when the ALU consumes on the same edge.
      if (snoop) begin
        data_n    = wb_data;
        fwd_hit_n = 1'b1;
      end
      if (consume) begin
        valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data    <= DATA_RST;
      tag     <= '0;
      is_reg  <= 1'b0;
      valid   <= 1'b0;
      fwd_hit <= 1'b0;
    end else begin
      data    <= data_n;
      tag     <= tag_n;
      is_reg  <= is_reg_n;
      valid   <= valid_n;
      fwd_hit <= fwd_hit_n;
    end
  end

endmodule

// File: rtl/operand_latch.sv
// Multi-channel operand latch feeding the ALU during the p3 operand-fetch
// phase. Instantiates NCH operand_channel blocks, fans out the shared
// control and writeback signals and flattens the per-channel outputs.
//   clock, reset : clock, async active-high reset
//   bus          : operand_latch_if slave (controls, register reads,
//                  immediate, writeback in; data_to_ALU/valid/fwd_hit out)
module operand_latch
  import proc_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NCH   = DEF_NCH,
  parameter int unsigned AW    = DEF_AW
) (
  input logic             clock,
  input logic             reset,
  operand_latch_if.slave  bus
);

  logic [NCH-1:0][WIDTH-1:0] ch_data;
  logic [NCH-1:0]            ch_valid;
  logic [NCH-1:0]            ch_fwd_hit;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    operand_channel #(
      .WIDTH (WIDTH),
      .AW    (AW)
    ) u_channel (
      .clock   (clock),
      .reset   (reset),
      .p3      (bus.p3),
      .stall   (bus.stall),
      .flush   (bus.flush),
      .consume (bus.consume),
      .rs_addr (bus.rs_addr[i*AW +: AW]),
      .rf_data (bus.rf_data[i*WIDTH +: WIDTH]),
      .imm_sel (bus.imm_sel[i]),
      .imm     (bus.imm),
      .wb_en   (bus.wb_en),
      .wb_addr (bus.wb_addr),
      .wb_data (bus.wb_data),
      .data    (ch_data[i]),
      .valid   (ch_valid[i]),
      .fwd_hit (ch_fwd_hit[i])
    );
  end

  assign bus.data_to_ALU = ch_data;
  assign bus.valid       = ch_valid;
  assign bus.fwd_hit     = ch_fwd_hit;

endmodule

// File: tb/tb_operand_latch.sv
// Testbench for operand_latch: default configuration (16b x 2ch, 3b addr)
// and a wide configuration (32b x 3ch, 4b addr) run side by side against a
// rule-level reference model, plus directed scenarios with fixed values.
module tb_operand_latch;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  operand_latch_if                                  b0 ();
  operand_latch_if #(.WIDTH(32), .NCH(3), .AW(4))   b1 ();

  operand_latch u0 (
    .clock (clock),
    .reset (reset),
    .bus   (b0)
  );

  operand_latch #(.WIDTH(32), .NCH(3), .AW(4)) u1 (
    .clock (clock),
    .reset (reset),
    .bus   (b1)
  );

  int checks   = 0;
  int failures = 0;

  // stimulus per configuration c (0 = default, 1 = wide)
  logic        s_p3[2], s_stall[2], s_flush[2], s_consume[2], s_wben[2];
  logic [3:0]  s_rs[2][3];
  logic [31:0] s_rf[2][3];
  logic        s_isel[2][3];
  logic [31:0] s_imm[2];
  logic [3:0]  s_wba[2];
  logic [31:0] s_wbd[2];

  // reference model state
  logic [31:0] m_data[2][3];
  logic [3:0]  m_tag[2][3];
  logic        m_isreg[2][3], m_valid[2][3], m_fwd[2][3];

  function automatic int nch_of(int c);
    return (c == 0) ? 2 : 3;
  endfunction

  function automatic logic [31:0] mask_of(int c);
    return (c == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int c = 0; c < 2; c++) begin
      s_p3[c] = 0; s_stall[c] = 0; s_flush[c] = 0; s_consume[c] = 0;
      s_wben[c] = 0; s_imm[c] = '0; s_wba[c] = '0; s_wbd[c] = '0;
      for (int i = 0; i < 3; i++) begin
        s_rs[c][i] = '0; s_rf[c][i] = '0; s_isel[c][i] = 0;
      end
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 3; i++) begin
        m_data[c][i] = '0; m_tag[c][i] = '0;
        m_isreg[c][i] = 0; m_valid[c][i] = 0; m_fwd[c][i] = 0;
      end
  endtask

  // One rising edge of the behavioural rules for configuration c.
  task automatic model_step(int c);
    logic cap;
    cap = s_p3[c] && !s_stall[c] && !s_flush[c];
    for (int i = 0; i < nch_of(c); i++) begin
      if (s_flush[c]) begin
        m_valid[c][i] = 0;
        m_isreg[c][i] = 0;
      end else if (cap) begin
        m_valid[c][i] = 1;
        if (s_isel[c][i]) begin
          m_data[c][i]  = s_imm[c];
          m_isreg[c][i] = 0;
          m_fwd[c][i]   = 0;
        end else begin
          m_tag[c][i]   = s_rs[c][i];
          m_isreg[c][i] = 1;
          if (s_wben[c] && s_wba[c] == s_rs[c][i]) begin
            m_data[c][i] = s_wbd[c];
            m_fwd[c][i]  = 1;
          end else begin
            m_data[c][i] = s_rf[c][i];
            m_fwd[c][i]  = 0;
          end
        end
      end else begin
        if (m_valid[c][i] && m_isreg[c][i] && s_wben[c] && s_wba[c] == m_tag[c][i]) begin
          m_data[c][i] = s_wbd[c];
          m_fwd[c][i]  = 1;
        end
        if (s_consume[c]) m_valid[c][i] = 0;
      end
    end
  endtask

  task automatic drive();
    b0.p3      = s_p3[0];
    b0.stall   = s_stall[0];
    b0.flush   = s_flush[0];
    b0.consume = s_consume[0];
    b0.rs_addr = {s_rs[0][1][2:0], s_rs[0][0][2:0]};
    b0.rf_data = {s_rf[0][1][15:0], s_rf[0][0][15:0]};
    b0.imm_sel = {s_isel[0][1], s_isel[0][0]};
    b0.imm     = s_imm[0][15:0];
    b0.wb_en   = s_wben[0];
    b0.wb_addr = s_wba[0][2:0];
    b0.wb_data = s_wbd[0][15:0];

    b1.p3      = s_p3[1];
    b1.stall   = s_stall[1];
    b1.flush   = s_flush[1];
    b1.consume = s_consume[1];
    b1.rs_addr = {s_rs[1][2], s_rs[1][1], s_rs[1][0]};
    b1.rf_data = {s_rf[1][2], s_rf[1][1], s_rf[1][0]};
    b1.imm_sel = {s_isel[1][2], s_isel[1][1], s_isel[1][0]};
    b1.imm     = s_imm[1];
    b1.wb_en   = s_wben[1];
    b1.wb_addr = s_wba[1];
    b1.wb_data = s_wbd[1];
  endtask

  task automatic compare_all();
    logic [95:0] ed;
    logic [2:0]  ev, ef;
    for (int c = 0; c < 2; c++) begin
      ed = '0; ev = '0; ef = '0;
      for (int i = 0; i < nch_of(c); i++) begin
        ed = ed | (96'(m_data[c][i] & mask_of(c)) << (i * ((c == 0) ? 16 : 32)));
        ev[i] = m_valid[c][i];
        ef[i] = m_fwd[c][i];
      end
      if (c == 0) begin
        check("cfg0_data",  b0.data_to_ALU, ed);
        check("cfg0_valid", b0.valid,       ev);
        check("cfg0_fwd",   b0.fwd_hit,     ef);
      end else begin
        check("cfg1_data",  b1.data_to_ALU, ed);
        check("cfg1_valid", b1.valid,       ev);
        check("cfg1_fwd",   b1.fwd_hit,     ef);
      end
    end
  endtask

  task automatic step();
    drive();
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic rand_stim(int c);
    logic [3:0] amax;
    amax = (c == 0) ? 4'd7 : 4'd15;
    s_p3[c]      = ($urandom_range(0, 9) < 6);
    s_stall[c]   = ($urandom_range(0, 9) < 2);
    s_flush[c]   = ($urandom_range(0, 11) == 0);
    s_consume[c] = ($urandom_range(0, 9) < 3);
    s_wben[c]    = ($urandom_range(0, 9) < 5);
    s_imm[c]     = $urandom & mask_of(c);
    s_wbd[c]     = $urandom & mask_of(c);
    for (int i = 0; i < 3; i++) begin
      s_rs[c][i]   = 4'($urandom_range(0, 32'(amax)));
      s_rf[c][i]   = $urandom & mask_of(c);
      s_isel[c][i] = ($urandom_range(0, 9) < 3);
    end
    // Aim the writeback at a live source index half the time.
    if ($urandom_range(0, 1) == 1)
      s_wba[c] = s_rs[c][$urandom_range(0, nch_of(c) - 1)];
    else
      s_wba[c] = 4'($urandom_range(0, 32'(amax)));
  endtask

  initial begin
    reset = 1'b1;
    clear_stim();
    drive();
    model_reset();
    #12;
    compare_all();
    check("reset_data", b0.data_to_ALU, 32'h0);
    reset = 1'b0;

    // plain capture: ch1 = r3 / 0x1234, ch0 = r5 / 0xABCD
    s_p3[0] = 1;
    s_rs[0][1] = 4'd3; s_rs[0][0] = 4'd5;
    s_rf[0][1] = 32'h1234; s_rf[0][0] = 32'hABCD;
    step();
    check("plain_data",  b0.data_to_ALU, 32'h1234_ABCD);
    check("plain_valid", b0.valid, 2'b11);
    check("plain_fwd",   b0.fwd_hit, 2'b00);

    // same-cycle bypass on r5
    s_wben[0] = 1; s_wba[0] = 4'd5; s_wbd[0] = 32'h00FF;
    step();
    check("bypass_data", b0.data_to_ALU, 32'h1234_00FF);
    check("bypass_fwd",  b0.fwd_hit, 2'b01);

    // immediate on ch0, r2 on ch1, then late writeback to r2
    s_wben[0] = 0; s_isel[0][0] = 1; s_imm[0] = 32'h0042;
    s_rs[0][1] = 4'd2; s_rf[0][1] = 32'h1111;
    step();
    check("imm_data", b0.data_to_ALU, 32'h1111_0042);
    s_p3[0] = 0; s_wben[0] = 1; s_wba[0] = 4'd2; s_wbd[0] = 32'h7777;
    step();
    check("snoop_data", b0.data_to_ALU, 32'h7777_0042);
    check("snoop_fwd",  b0.fwd_hit, 2'b10);
    s_wben[0] = 0; s_consume[0] = 1;
    step();
    check("consume_valid", b0.valid, 2'b00);
    s_consume[0] = 0; s_wben[0] = 1; s_wbd[0] = 32'h9999;
    step();
    check("nosnoop_invalid", b0.data_to_ALU, 32'h7777_0042);

    // stall, capture, flush with p3, consume with p3
    s_wben[0] = 0; s_isel[0][0] = 0; s_p3[0] = 1; s_stall[0] = 1;
    s_rs[0][1] = 4'd1; s_rs[0][0] = 4'd4;
    s_rf[0][1] = 32'hAAAA; s_rf[0][0] = 32'hBBBB;
    step();
    check("stall_data", b0.data_to_ALU, 32'h7777_0042);
    s_stall[0] = 0;
    step();
    check("cap_data", b0.data_to_ALU, 32'hAAAA_BBBB);
    s_flush[0] = 1; s_rf[0][1] = 32'hCCCC; s_rf[0][0] = 32'hDDDD;
    step();
    check("flush_valid", b0.valid, 2'b00);
    check("flush_data",  b0.data_to_ALU, 32'hAAAA_BBBB);
    s_flush[0] = 0; s_consume[0] = 1;
    s_rf[0][1] = 32'hEEEE; s_rf[0][0] = 32'h1357;
    step();
    check("capcons_data",  b0.data_to_ALU, 32'hEEEE_1357);
    check("capcons_valid", b0.valid, 2'b11);

    // wide configuration: bypass on ch2 through r15
    clear_stim();
    s_p3[1] = 1;
    s_rs[1][2] = 4'd15; s_rs[1][1] = 4'd2; s_rs[1][0] = 4'd1;
    s_rf[1][2] = 32'h3333_3333; s_rf[1][1] = 32'h2222_2222; s_rf[1][0] = 32'h1111_1111;
    s_wben[1] = 1; s_wba[1] = 4'd15; s_wbd[1] = 32'hDEAD_BEEF;
    step();
    check("wide_ch2",   b1.data_to_ALU[95:64], 32'hDEAD_BEEF);
    check("wide_fwd",   b1.fwd_hit, 3'b100);
    check("wide_valid", b1.valid, 3'b111);

    // asynchronous reset in the middle of a cycle with channels loaded
    clear_stim();
    s_p3[0] = 1; s_rf[0][0] = 32'h5A5A; s_rf[0][1] = 32'hA5A5;
    step();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_data",  b0.data_to_ALU, 32'h0);
    check("async_valid", b0.valid, 2'b00);
    check("async_fwd",   b0.fwd_hit, 2'b00);
    compare_all();
    @(posedge clock);
    #1;
    reset = 1'b0;
    compare_all();

    // randomized traffic on both configurations
    for (int n = 0; n < 800; n++) begin
      rand_stim(0);
      rand_stim(1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
